// File: rtl/shift_reg_ctrl.sv
// Multi-step shift register with parallel load and a busy/done handshake.
// Optional rotate mode is built in when SHREG_ROTATE_EN is defined.
module shift_reg_ctrl #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    input  logic             rot,
    input  logic             stall,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_SHR  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             r_ser;
    logic             w_ser_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [AMT_W-1:0] r_cnt;
    logic [AMT_W-1:0] w_cnt_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             r_rot;
    logic             w_rot_nxt;
    logic             w_rot_in;
    logic [WIDTH:0]   w_step;

    // One shift step; result is {bit shifted out, new register value}.
    function automatic logic [WIDTH:0] shift_step(
        input logic [WIDTH-1:0] cur,
        input logic             dir_right,
        input logic             do_rot,
        input logic             fill_in
    );
        logic           fill;
        logic [WIDTH:0] res;
        if (dir_right) begin
            fill = do_rot ? cur[0] : fill_in;
            res  = {cur[0], fill, cur[WIDTH-1:1]};
        end else begin
            fill = do_rot ? cur[WIDTH-1] : fill_in;
            res  = {cur[WIDTH-1], cur[WIDTH-2:0], fill};
        end
        return res;
    endfunction

`ifdef SHREG_ROTATE_EN
    assign w_rot_in = rot;
`else
    // Rotate is compiled out; rot is deliberately left without effect.
    logic w_unused_rot;
    assign w_unused_rot = rot;
    assign w_rot_in     = 1'b0;
`endif

    // Next-state and next-output logic for the IDLE/SHIFT controller.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_ser_nxt   = r_ser;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_rot_nxt   = r_rot;
        w_step      = '0;

        case (r_state)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
                if (start) begin
                    case (op)
                        OP_NOP: begin
                            w_done_nxt = 1'b0;
                        end
                        OP_LOAD: begin
                            w_q_nxt    = d;
                            w_done_nxt = 1'b1;
                        end
                        OP_SHL, OP_SHR: begin
                            w_dir_nxt = op[0];
                            w_rot_nxt = w_rot_in;
                            if (amt == {AMT_W{1'b0}}) begin
                                w_done_nxt = 1'b1;
                            end else begin
                                // First step happens on the accepting edge.
                                w_step    = shift_step(r_q, op[0], w_rot_in, ser_in);
                                w_q_nxt   = w_step[WIDTH-1:0];
                                w_ser_nxt = w_step[WIDTH];
                                if (amt == AMT_W'(1)) begin
                                    w_done_nxt = 1'b1;
                                end else begin
                                    w_cnt_nxt   = amt - AMT_W'(1);
                                    w_busy_nxt  = 1'b1;
                                    w_state_nxt = ST_SHIFT;
                                end
                            end
                        end
                        default: begin
                            w_done_nxt = 1'b0;
                        end
                    endcase
                end else begin
                    w_done_nxt = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (stall) begin
                    w_busy_nxt = 1'b1;
                end else begin
                    w_step    = shift_step(r_q, r_dir, r_rot, ser_in);
                    w_q_nxt   = w_step[WIDTH-1:0];
                    w_ser_nxt = w_step[WIDTH];
                    w_cnt_nxt = r_cnt - AMT_W'(1);
                    // A count of 0 cannot occur here; treat it as final for robustness.
                    if (r_cnt <= AMT_W'(1)) begin
                        w_cnt_nxt   = {AMT_W{1'b0}};
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_busy_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = {AMT_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_q     <= {WIDTH{1'b0}};
            r_ser   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= {AMT_W{1'b0}};
            r_dir   <= 1'b0;
            r_rot   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_ser   <= w_ser_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_rot   <= w_rot_nxt;
        end
    end

    assign q       = r_q;
    assign ser_out = r_ser;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Self-checking bench for shift_reg_ctrl: per-cycle vector table plus
// hand-written sequences for long shifts.
module tb_shift_reg_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [3:0] amt;
    logic [7:0] d;
    logic       ser_in;
    logic       rot;
    logic       stall;
    logic [7:0] q;
    logic       ser_out;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    shift_reg_ctrl #(.WIDTH(8), .AMT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .amt(amt), .d(d),
        .ser_in(ser_in), .rot(rot), .stall(stall), .q(q), .ser_out(ser_out),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       reset;
        logic       start;
        logic [1:0] op;
        logic [3:0] amt;
        logic [7:0] d;
        logic       ser_in;
        logic       rot;
        logic       stall;
        logic [7:0] eq;
        logic       eso;
        logic       ebusy;
        logic       edone;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

`ifdef SHREG_ROTATE_EN
    localparam logic [7:0] ROT_Q = 8'h80;
`else
    localparam logic [7:0] ROT_Q = 8'h00;
`endif

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got q/so/busy/done=%h/%b/%b/%b expected %h/%b/%b/%b",
                     name, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        int edges;
        int busy_cycles;

        reset = 1'b1; start = 1'b0; op = 2'b00; amt = 4'd0; d = 8'h00;
        ser_in = 1'b0; rot = 1'b0; stall = 1'b0;

        //          rst   st    op     amt    d      sin   rot   stl    q      so    busy  done
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 2'b01, 4'd0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 2'b10, 4'd5, 8'h00, 1'b1, 1'b0, 1'b0, 8'h79, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'b00, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 2'b00, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 2'b01, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'b10, 4'd3, 8'h00, 1'b1, 1'b0, 1'b0, 8'h4B, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h97, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h2F, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 2'b11, 4'd2, 8'h00, 1'b0, 1'b0, 1'b0, 8'h17, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h17, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h0B, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h0B, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 2'b00, 4'd3, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h0B, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 2'b10, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h0B, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 2'b10, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h16, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 2'b10, 4'd3, 8'h00, 1'b0, 1'b0, 1'b0, 8'h2C, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 2'b01, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h58, 1'b0, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hB0, 1'b0, 1'b0, 1'b1};
        vecs[20] = '{1'b0, 1'b1, 2'b11, 4'd4, 8'h00, 1'b1, 1'b0, 1'b0, 8'hD8, 1'b0, 1'b1, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 2'b00, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[23] = '{1'b0, 1'b1, 2'b01, 4'd0, 8'h01, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1};
        vecs[24] = '{1'b0, 1'b1, 2'b11, 4'd1, 8'h00, 1'b0, 1'b1, 1'b0, ROT_Q, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset  = vecs[i].reset;
            start  = vecs[i].start;
            op     = vecs[i].op;
            amt    = vecs[i].amt;
            d      = vecs[i].d;
            ser_in = vecs[i].ser_in;
            rot    = vecs[i].rot;
            stall  = vecs[i].stall;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), {q, ser_out, busy, done},
                  {vecs[i].eq, vecs[i].eso, vecs[i].ebusy, vecs[i].edone});
        end

        // Shift amount beyond WIDTH: register ends fully filled with ser_in.
        @(negedge clk);
        reset = 1'b0; start = 1'b1; op = 2'b11; amt = 4'd10; ser_in = 1'b1; rot = 1'b0; stall = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 1;
        busy_cycles = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            edges++;
        end
        check("long_shr_final", {q, ser_out, busy, done}, {8'hFF, 1'b1, 1'b0, 1'b1});
        checks++;
        if (edges != 10) begin
            errors++;
            $display("FAIL long_shr_edges: got %0d expected 10", edges);
        end
        checks++;
        if (busy_cycles != 9) begin
            errors++;
            $display("FAIL long_shr_busy: got %0d expected 9", busy_cycles);
        end
        @(posedge clk);
        #1;
        check("long_shr_done_clear", {q, ser_out, busy, done}, {8'hFF, 1'b1, 1'b0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
